mem_wb_pipe_reg: RTL and testbench

Parametrised MEM→WB pipeline register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a write-back value mux. It replaces the fixed, always-advancing MEM/WB latch, so the write-back stage can stall without dropping a memory result. It sits between the data-memory stage and the register-file write port.

---
 rtl/mem_wb_pipe_reg_pkg.sv | 27 ++
 rtl/pipe_skid_buf.sv | 80 ++++++++
 rtl/mem_wb_pipe_reg.sv | 71 +++++++
 tb/tb_mem_wb_pipe_reg.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pipe_reg_pkg.sv
// Shared types and constants for the MEM/WB pipeline register and its skid buffer.
package mem_wb_pipe_reg_pkg;

    localparam int unsigned WORD_LEN_DEF      = 32;
    localparam int unsigned REG_FILE_ADDR_LEN = 5;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skid_state_e;

    // Payload layout at default widths; the top packs in the same field order.
    typedef struct packed {
        logic                         wb_en;
        logic                         mem_r_en;
        logic [REG_FILE_ADDR_LEN-1:0] dest;
        logic [WORD_LEN_DEF-1:0]      alu_res;
        logic [WORD_LEN_DEF-1:0]      mem_val;
    } mem_wb_payload_t;

    function automatic int unsigned payload_width(input int unsigned word_len,
                                                  input int unsigned addr_len);
        return 2 + addr_len + 2 * word_len;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic width-parametrised valid/ready register with a one-entry skid slot.
module pipe_skid_buf
    import mem_wb_pipe_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             accept, drain;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_q;
    assign accept    = in_valid & in_ready_q;
    assign drain     = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Payload registers keep their contents; only the state forgets them.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && drain) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = StFull;
                    end else if (drain) begin
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StEmpty;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != StFull);
        end
    end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB pipeline register with skid buffer, flush, dest-zero squash and write-back mux.
// Optional forwarding outputs are enabled by defining MEMWB_BYPASS_EN.
module mem_wb_pipe_reg
    import mem_wb_pipe_reg_pkg::*;
#(
    parameter int unsigned WORD_LEN         = WORD_LEN_DEF,
    parameter int unsigned REG_ADDR_LEN     = REG_FILE_ADDR_LEN,
    parameter bit          ZERO_DEST_SQUASH = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_wb_en,
    input  logic                    in_mem_r_en,
    input  logic [WORD_LEN-1:0]     in_alu_res,
    input  logic [WORD_LEN-1:0]     in_mem_val,
    input  logic [REG_ADDR_LEN-1:0] in_dest,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_wb_en,
    output logic                    out_mem_r_en,
    output logic [WORD_LEN-1:0]     out_alu_res,
    output logic [WORD_LEN-1:0]     out_mem_val,
    output logic [REG_ADDR_LEN-1:0] out_dest,
`ifdef MEMWB_BYPASS_EN
    output logic                    byp_valid,
    output logic [REG_ADDR_LEN-1:0] byp_dest,
    output logic [WORD_LEN-1:0]     byp_value,
`endif
    output logic [WORD_LEN-1:0]     wb_value
);

    localparam int unsigned PAYLOAD_W = payload_width(WORD_LEN, REG_ADDR_LEN);

    logic [PAYLOAD_W-1:0] in_payload;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 held_wb_en;
    logic                 dest_squash;

    assign in_payload = {in_wb_en, in_mem_r_en, in_dest, in_alu_res, in_mem_val};

    pipe_skid_buf #(
        .WIDTH(PAYLOAD_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_payload)
    );

    assign {held_wb_en, out_mem_r_en, out_dest, out_alu_res, out_mem_val} = out_payload;

    // r0 is hardwired, so a write to it is dropped but the entry still retires.
    assign dest_squash = ZERO_DEST_SQUASH && (out_dest == '0);
    assign out_wb_en   = out_valid & held_wb_en & ~dest_squash;
    assign wb_value    = out_mem_r_en ? out_mem_val : out_alu_res;

`ifdef MEMWB_BYPASS_EN
    assign byp_valid = out_valid & out_wb_en;
    assign byp_dest  = out_dest;
    assign byp_value = wb_value;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg; a second instance checks ZERO_DEST_SQUASH=0.
module tb_mem_wb_pipe_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_wb_en = 1'b0;
    logic        in_mem_r_en = 1'b0;
    logic [31:0] in_alu_res = '0;
    logic [31:0] in_mem_val = '0;
    logic [4:0]  in_dest = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_wb_en, out_mem_r_en;
    logic [31:0] out_alu_res, out_mem_val, wb_value;
    logic [4:0]  out_dest;

    logic        n_in_ready, n_out_valid, n_out_wb_en, n_out_mem_r_en;
    logic [31:0] n_out_alu_res, n_out_mem_val, n_wb_value;
    logic [4:0]  n_out_dest;

`ifdef MEMWB_BYPASS_EN
    logic        byp_valid, n_byp_valid;
    logic [4:0]  byp_dest, n_byp_dest;
    logic [31:0] byp_value, n_byp_value;
`endif

    mem_wb_pipe_reg #(
        .WORD_LEN(32), .REG_ADDR_LEN(5), .ZERO_DEST_SQUASH(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_alu_res(in_alu_res),
        .in_mem_val(in_mem_val), .in_dest(in_dest), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_wb_en(out_wb_en),
        .out_mem_r_en(out_mem_r_en), .out_alu_res(out_alu_res),
        .out_mem_val(out_mem_val), .out_dest(out_dest),
`ifdef MEMWB_BYPASS_EN
        .byp_valid(byp_valid), .byp_dest(byp_dest), .byp_value(byp_value),
`endif
        .wb_value(wb_value)
    );

    mem_wb_pipe_reg #(
        .WORD_LEN(32), .REG_ADDR_LEN(5), .ZERO_DEST_SQUASH(1'b0)
    ) dut_nosq (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
        .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en), .in_alu_res(in_alu_res),
        .in_mem_val(in_mem_val), .in_dest(in_dest), .flush(flush),
        .out_valid(n_out_valid), .out_ready(out_ready), .out_wb_en(n_out_wb_en),
        .out_mem_r_en(n_out_mem_r_en), .out_alu_res(n_out_alu_res),
        .out_mem_val(n_out_mem_val), .out_dest(n_out_dest),
`ifdef MEMWB_BYPASS_EN
        .byp_valid(n_byp_valid), .byp_dest(n_byp_dest), .byp_value(n_byp_value),
`endif
        .wb_value(n_wb_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb_en;
        logic        mem_r_en;
        logic [4:0]  dest;
        logic [31:0] alu_res;
        logic [31:0] mem_val;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on drain, all sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst || flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_drain", 64'(out_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check_eq("out_dest", 64'(out_dest), 64'(e.dest));
                    check_eq("out_alu_res", 64'(out_alu_res), 64'(e.alu_res));
                    check_eq("out_mem_val", 64'(out_mem_val), 64'(e.mem_val));
                    check_eq("out_mem_r_en", 64'(out_mem_r_en), 64'(e.mem_r_en));
                    check_eq("wb_value", 64'(wb_value),
                             64'(e.mem_r_en ? e.mem_val : e.alu_res));
                    check_eq("out_wb_en_sq", 64'(out_wb_en),
                             64'(e.wb_en && (e.dest != 5'd0)));
                    check_eq("out_wb_en_nosq", 64'(n_out_wb_en), 64'(e.wb_en));
                end
            end
            if (in_valid && in_ready) begin
                e.wb_en    = in_wb_en;
                e.mem_r_en = in_mem_r_en;
                e.dest     = in_dest;
                e.alu_res  = in_alu_res;
                e.mem_val  = in_mem_val;
                sb.push_back(e);
            end
        end
    end

    // Drives one entry and holds it until accepted; leaves in_valid high for back-to-back use.
    task automatic send(input logic [4:0] d, input logic [31:0] alu, input logic [31:0] mv,
                        input logic mr, input logic wb);
        logic acc;
        int   n;
        in_valid    = 1'b1;
        in_dest     = d;
        in_alu_res  = alu;
        in_mem_val  = mv;
        in_mem_r_en = mr;
        in_wb_en    = wb;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check_eq("send_accept", 64'(in_ready), 64'(1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with live input: nothing may be captured.
        rst = 1'b0; in_valid = 1'b1; in_wb_en = 1'b1; in_dest = 5'd5;
        in_alu_res = 32'h1234; in_mem_val = 32'h5678; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_in_ready", 64'(in_ready), 64'(1));
        check_eq("rst_out_wb_en", 64'(out_wb_en), 64'(0));
        check_eq("rst_out_mem_r_en", 64'(out_mem_r_en), 64'(0));
        check_eq("rst_out_alu_res", 64'(out_alu_res), 64'(0));
        check_eq("rst_out_mem_val", 64'(out_mem_val), 64'(0));
        check_eq("rst_out_dest", 64'(out_dest), 64'(0));
        check_eq("rst_wb_value", 64'(wb_value), 64'(0));
        in_valid = 1'b0;
        rst = 1'b1;
        idle(2);

        // First accept is visible one cycle later.
        send(5'd9, 32'h99, 32'h77, 1'b0, 1'b1);
        check_eq("latency_valid", 64'(out_valid), 64'(1));
        idle(2);

        // Back-to-back stream with mem_r_en alternating.
        for (int i = 1; i <= 8; i++) begin
            send(5'(i), 32'h100 + 32'(i), 32'h200 + 32'(i), i[0], 1'b1);
            check_eq("stream_valid", 64'(out_valid), 64'(1));
            check_eq("stream_in_ready", 64'(in_ready), 64'(1));
        end
        idle(3);
        check_eq("stream_drained", 64'(out_valid), 64'(0));

        // Backpressure: one extra entry absorbed, then in_ready drops.
        out_ready = 1'b0;
        send(5'd10, 32'hA0, 32'hB0, 1'b0, 1'b1);
        send(5'd11, 32'hA1, 32'hB1, 1'b1, 1'b1);
        check_eq("bp_in_ready_low", 64'(in_ready), 64'(0));
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        check_eq("bp_in_ready_held", 64'(in_ready), 64'(0));
        out_ready = 1'b1;
        send(5'd12, 32'hA2, 32'hB2, 1'b0, 1'b1);
        send(5'd13, 32'hA3, 32'hB3, 1'b1, 1'b0);
        idle(4);
        check_eq("bp_drained", 64'(out_valid), 64'(0));

        // Flush while FULL with a competing input.
        out_ready = 1'b0;
        send(5'd14, 32'hE0, 32'hE1, 1'b0, 1'b1);
        send(5'd15, 32'hF0, 32'hF1, 1'b0, 1'b1);
        check_eq("full_in_ready", 64'(in_ready), 64'(0));
        flush = 1'b1; in_valid = 1'b1; in_dest = 5'd16; in_alu_res = 32'h6666;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_full_valid", 64'(out_valid), 64'(0));
        check_eq("flush_full_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        idle(3);
        check_eq("flush_full_quiet", 64'(out_valid), 64'(0));

        // Flush while ONE: the same-cycle accept must be discarded.
        out_ready = 1'b0;
        send(5'd17, 32'h1717, 32'h0, 1'b0, 1'b1);
        flush = 1'b1; in_valid = 1'b1; in_dest = 5'd18; in_alu_res = 32'h1818;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check_eq("flush_one_valid", 64'(out_valid), 64'(0));
        check_eq("flush_one_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        idle(3);
        check_eq("flush_one_quiet", 64'(out_valid), 64'(0));

        // Destination zero write is squashed only with the parameter set.
        out_ready = 1'b0;
        send(5'd0, 32'hDEAD, 32'h0, 1'b0, 1'b1);
        in_valid = 1'b0;
        check_eq("dz_valid", 64'(out_valid), 64'(1));
        check_eq("dz_wb_en_sq", 64'(out_wb_en), 64'(0));
        check_eq("dz_wb_en_nosq", 64'(n_out_wb_en), 64'(1));
        check_eq("dz_wb_value", 64'(wb_value), 64'(32'hDEAD));
        out_ready = 1'b1;
        idle(2);

`ifdef MEMWB_BYPASS_EN
        out_ready = 1'b0;
        send(5'd7, 32'h1111, 32'hCAFE, 1'b1, 1'b1);
        in_valid = 1'b0;
        check_eq("byp_valid", 64'(byp_valid), 64'(1));
        check_eq("byp_dest", 64'(byp_dest), 64'(7));
        check_eq("byp_value", 64'(byp_value), 64'(32'hCAFE));
        out_ready = 1'b1;
        idle(2);
        check_eq("byp_valid_gone", 64'(byp_valid), 64'(0));
`endif

        // Reset mid-stream drops everything held.
        out_ready = 1'b0;
        send(5'd20, 32'h2020, 32'h0, 1'b0, 1'b1);
        send(5'd21, 32'h2121, 32'h0, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("mrst_out_valid", 64'(out_valid), 64'(0));
        check_eq("mrst_alu_res", 64'(out_alu_res), 64'(0));
        check_eq("mrst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        out_ready = 1'b1;
        idle(3);
        check_eq("mrst_quiet", 64'(out_valid), 64'(0));
        check_eq("sb_leftover", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
